// File: rtl/ps2_scan_ctrl.sv
// PS/2 scan-code sequencer: drains the receive FIFO one byte at a time,
// folds E0/F0 prefixes into single key events, filters typematic repeats,
// tracks shift/ctrl state and hands events downstream on valid/ready.
module ps2_scan_ctrl (
  input  logic       clk,
  input  logic       clrn,
  input  logic [7:0] fifo_data,
  input  logic       fifo_ready,
  input  logic       fifo_overflow,
  output logic       fifo_nextdata_n,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_break,
  output logic       shift_flag,
  output logic       ctrl_flag,
  output logic [7:0] press_cnt,
  output logic       err_flag
);

  typedef enum logic [1:0] {IDLE, POP, DECODE, EMIT} state_t;

  state_t     state, state_nxt;
  logic [7:0] byte_q, byte_nxt;
  logic       ext_pend, ext_pend_nxt;
  logic       brk_pend, brk_pend_nxt;
  logic       held_vld, held_vld_nxt;
  logic       held_ext, held_ext_nxt;
  logic [7:0] held_code, held_code_nxt;
  logic       lshift, lshift_nxt;
  logic       rshift, rshift_nxt;
  logic       lctrl, lctrl_nxt;
  logic       rctrl, rctrl_nxt;
  logic [7:0] evt_code_nxt;
  logic       evt_ext_nxt;
  logic       evt_brk_nxt;
  logic [7:0] press_nxt;
  logic       err_nxt;
  logic       key_match;

  // A code matches the held key only when a key is actually held.
  assign key_match = held_vld && ({ext_pend, byte_q} == {held_ext, held_code});

  // State register.
  always_ff @(posedge clk) begin
    if (!clrn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and next-value logic for every register in the block.
  always_comb begin
    state_nxt     = state;
    byte_nxt      = byte_q;
    ext_pend_nxt  = ext_pend;
    brk_pend_nxt  = brk_pend;
    held_vld_nxt  = held_vld;
    held_ext_nxt  = held_ext;
    held_code_nxt = held_code;
    lshift_nxt    = lshift;
    rshift_nxt    = rshift;
    lctrl_nxt     = lctrl;
    rctrl_nxt     = rctrl;
    evt_code_nxt  = evt_code;
    evt_ext_nxt   = evt_ext;
    evt_brk_nxt   = evt_break;
    press_nxt     = press_cnt;
    err_nxt       = err_flag | fifo_overflow;
    case (state)
      IDLE: begin
        if (fifo_ready) begin
          byte_nxt  = fifo_data;
          state_nxt = POP;
        end
      end
      POP: state_nxt = DECODE;
      DECODE: begin
        state_nxt    = IDLE;
        ext_pend_nxt = 1'b0;
        brk_pend_nxt = 1'b0;
        case (byte_q)
          8'hE0: begin
            ext_pend_nxt = 1'b1;
            brk_pend_nxt = brk_pend;
          end
          8'hF0: begin
            ext_pend_nxt = ext_pend;
            brk_pend_nxt = 1'b1;
          end
          8'h00, 8'hFF: err_nxt = 1'b1;
          8'hAA: begin
            // Self-test pass: dropped, pend bits already cleared above.
          end
          default: begin
            // Modifiers follow every code, repeats included.
            if (!ext_pend && byte_q == 8'h12) lshift_nxt = !brk_pend;
            if (!ext_pend && byte_q == 8'h59) rshift_nxt = !brk_pend;
            if (!ext_pend && byte_q == 8'h14) lctrl_nxt  = !brk_pend;
            if (ext_pend  && byte_q == 8'h14) rctrl_nxt  = !brk_pend;
            if (!brk_pend) begin
              if (!key_match) begin
                held_vld_nxt  = 1'b1;
                held_ext_nxt  = ext_pend;
                held_code_nxt = byte_q;
                press_nxt     = press_cnt + 8'd1;
                evt_code_nxt  = byte_q;
                evt_ext_nxt   = ext_pend;
                evt_brk_nxt   = 1'b0;
                state_nxt     = EMIT;
              end
            end else begin
              if (key_match) held_vld_nxt = 1'b0;
              evt_code_nxt = byte_q;
              evt_ext_nxt  = ext_pend;
              evt_brk_nxt  = 1'b1;
              state_nxt    = EMIT;
            end
          end
        endcase
      end
      EMIT: begin
        if (evt_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Captured FIFO byte; pure data, so no reset.
  always_ff @(posedge clk) begin
    byte_q <= byte_nxt;
  end

  // Control and output registers; outputs are loaded from next-state values so none is combinational.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      ext_pend        <= 1'b0;
      brk_pend        <= 1'b0;
      held_vld        <= 1'b0;
      held_ext        <= 1'b0;
      held_code       <= 8'h00;
      lshift          <= 1'b0;
      rshift          <= 1'b0;
      lctrl           <= 1'b0;
      rctrl           <= 1'b0;
      fifo_nextdata_n <= 1'b1;
      evt_valid       <= 1'b0;
      evt_code        <= 8'h00;
      evt_ext         <= 1'b0;
      evt_break       <= 1'b0;
      shift_flag      <= 1'b0;
      ctrl_flag       <= 1'b0;
      press_cnt       <= 8'h00;
      err_flag        <= 1'b0;
    end else begin
      ext_pend        <= ext_pend_nxt;
      brk_pend        <= brk_pend_nxt;
      held_vld        <= held_vld_nxt;
      held_ext        <= held_ext_nxt;
      held_code       <= held_code_nxt;
      lshift          <= lshift_nxt;
      rshift          <= rshift_nxt;
      lctrl           <= lctrl_nxt;
      rctrl           <= rctrl_nxt;
      fifo_nextdata_n <= (state_nxt != POP);
      evt_valid       <= (state_nxt == EMIT);
      evt_code        <= evt_code_nxt;
      evt_ext         <= evt_ext_nxt;
      evt_break       <= evt_brk_nxt;
      shift_flag      <= lshift_nxt | rshift_nxt;
      ctrl_flag       <= lctrl_nxt | rctrl_nxt;
      press_cnt       <= press_nxt;
      err_flag        <= err_nxt;
    end
  end

endmodule

// File: doc/ps2_scan_ctrl.md
# ps2_scan_ctrl

Sequencing controller between the PS/2 receive FIFO and the display/consumer logic. It drains the FIFO through its `ready`/`nextdata_n` handshake and assembles multi-byte scan codes (`E0` extended and `F0` break prefixes) into single key events. It filters typematic auto-repeat, tracks shift/ctrl state, counts key presses and flags errors. Key events go downstream on a valid/ready handshake, and backpressure stalls FIFO reads.

## Interface
- No parameters; all widths fixed.
- `clk` in 1: system clock; all state updates on rising edge.
- `clrn` in 1: reset; synchronous, active-low.
- `fifo_data` in 8: byte at FIFO head; stable while `fifo_ready`=1 and no pop issued.
- `fifo_ready` in 1: FIFO non-empty.
- `fifo_overflow` in 1: FIFO overflow indication.
- `fifo_nextdata_n` out 1: active-low pop; FIFO advances on each clock edge where it is 0.
- `evt_valid` out 1: key event available.
- `evt_ready` in 1: consumer accepts event.
- `evt_code` out 8: scan code (prefixes stripped).
- `evt_ext` out 1: event was `E0`-prefixed.
- `evt_break` out 1: event is a release (`F0`-prefixed).
- `shift_flag` out 1: left or right shift held.
- `ctrl_flag` out 1: left or right ctrl held.
- `press_cnt` out 8: count of accepted make events.
- `err_flag` out 1: sticky error.

## Operation
- FSM states: IDLE, POP, DECODE, EMIT. Reset state is IDLE.
- IDLE: if `fifo_ready`=1, latch `fifo_data` into `byte_q` and go to POP. Otherwise stay in IDLE.
- POP: `fifo_nextdata_n`=0 for exactly this one cycle, then go to DECODE. `fifo_nextdata_n`=1 in every other state.
- DECODE: actions depend on `byte_q`:
  - `E0`: set `ext_pend`, go to IDLE.
  - `F0`: set `brk_pend`, go to IDLE. Repeated or reordered prefixes just keep the pend bits set.
  - `00` or `FF`: set `err_flag`, clear both pend bits, go to IDLE. No event.
  - `AA`: discard, clear pend bits, go to IDLE.
  - Any other value: form the event {`ext_pend`, `brk_pend`, `byte_q`} and clear the pend bits, then:
    - Make, and {ext,code} equals the held key: repeat. Suppress it and go to IDLE. No event, no count.
    - Make, otherwise: record it as the held key, `press_cnt`+1 (wraps 255 to 0), go to EMIT.
    - Break: if {ext,code} matches the held key, clear the held key. Go to EMIT.
- Modifier tracking, updated in DECODE for every non-prefix code, suppressed repeats included:
  - `lshift`: non-ext `12`.
  - `rshift`: non-ext `59`.
  - `lctrl`: non-ext `14`.
  - `rctrl`: ext `14`.
  - Make sets the bit; break clears it.
  - `shift_flag` = lshift|rshift; `ctrl_flag` = lctrl|rctrl.
- EMIT: `evt_valid`=1 with `evt_*` held stable. On the cycle `evt_valid`&`evt_ready` go to IDLE and drop `evt_valid` next cycle. No FIFO pops while in EMIT.
- `err_flag` also sets on any cycle with `fifo_overflow`=1. It clears only on reset.

## Timing
- Reset (`clrn`=0 at an edge): outputs go to `fifo_nextdata_n`=1, `evt_valid`=0, `evt_code`=0, `evt_ext`=0, `evt_break`=0, `shift_flag`=0, `ctrl_flag`=0, `press_cnt`=0, `err_flag`=0. Internally: pend bits and held key cleared, state IDLE.
- Reset wins over every other event, including mid-POP and mid-EMIT; a pending event is dropped.
- Latency: `fifo_ready` seen in IDLE at cycle t gives POP at t+1, DECODE at t+2, and `evt_valid`=1 at t+3.
- Each byte costs at least 3 cycles, so a 3-byte release (`E0 F0 xx`) emits at t+9.
- Event to next pop: acceptance at cycle e gives IDLE at e+1 and the earliest next POP at e+2.
- POP is issued only after `fifo_ready` was sampled 1 in IDLE, so the FIFO is never popped when empty.
- All outputs are registered; none is combinational from inputs.

## Test plan
- Push `1C`, `evt_ready`=1 → one event: code=1C, ext=0, break=0, `evt_valid` 3 cycles after `fifo_ready`; `press_cnt`=1; `fifo_nextdata_n` low for exactly 1 cycle.
- Push `E0 75 E0 F0 75` → two events: {1,0,75} then {1,1,75}; 5 pops total; `press_cnt`=1.
- Push `1C 1C 1C F0 1C` (auto-repeat) → exactly two events: make 1C then break 1C; `press_cnt`=1.
- Push `12 1C F0 12` → `shift_flag` rises after the first DECODE and falls after the last. Events: make 12, make 1C, break 12. `press_cnt`=2.
- Hold `evt_ready`=0 for 20 cycles with `1C 32` queued → `evt_valid` held with code 1C and `fifo_nextdata_n` stays 1 throughout; after release, second event code=32.
- Push `FF`, pulse `fifo_overflow` → `err_flag`=1 and sticky, no event. Assert `clrn`=0 mid-EMIT → all outputs return to reset values the next cycle.
